// File: rtl/pdm_capture_if.sv
// pdm_capture_if -- signal bundle between the PDM capture front end and its
// surroundings (microphone pins on one side, beamformer PCM input on the other).
//
// Signals:
//   enable        capture run level (high = running)
//   pdm_data_in   raw PDM bits, bit k = mic k, asynchronous to clk
//   pdm_clk_out   shared PDM bit clock to all mics
//   pcm_data_out  packed offset-binary samples, mic k at [BIT_WIDTH*k +: BIT_WIDTH]
//   pcm_valid     one-cycle strobe, new frame on pcm_data_out
//   active        high while the capture is in its RUN state
//
// master: the capture block (drives the PDM clock and the PCM stream).
// slave : the consumer/controller side.
interface pdm_capture_if #(
  parameter int BIT_WIDTH = 8,
  parameter int NUM_MICS  = 25
);
  logic                          enable;
  logic [NUM_MICS-1:0]           pdm_data_in;
  logic                          pdm_clk_out;
  logic [BIT_WIDTH*NUM_MICS-1:0] pcm_data_out;
  logic                          pcm_valid;
  logic                          active;

  modport master (
    input  enable,
    input  pdm_data_in,
    output pdm_clk_out,
    output pcm_data_out,
    output pcm_valid,
    output active
  );

  modport slave (
    output enable,
    output pdm_data_in,
    input  pdm_clk_out,
    input  pcm_data_out,
    input  pcm_valid,
    input  active
  );
endinterface

// File: rtl/pdm_capture.sv
// pdm_capture -- multichannel PDM microphone front end.
// Generates the shared PDM bit clock, synchronizes one PDM line per mic,
// decimates each with a 3rd-order CIC (differential delay 1) and emits one
// offset-binary PCM frame for all mics with a single-cycle pcm_valid strobe.
// The first WARMUP decimated frames after each start only prime the filters.
//
// Ports:
//   clk    system clock (single domain)
//   rst_n  synchronous active-low reset, priority over enable
//   bus    pdm_capture_if.master: enable, pdm_data_in in; pdm_clk_out,
//          pcm_data_out, pcm_valid, active out
module pdm_capture #(
  parameter int BIT_WIDTH = 8,
  parameter int NUM_MICS  = 25,
  parameter int HALF_DIV  = 12,
  parameter int DECIM     = 64,
  parameter int WARMUP    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  pdm_capture_if.master bus
);
  localparam int W      = 3 * $clog2(DECIM) + 1;
  // One guard bit above W: the comb result spans -DECIM^3..+DECIM^3, and the
  // two extremes alias in W bits. With W+1 bits modular wrap still cancels
  // exactly, but +DECIM^3 stays distinguishable so it can be saturated.
  localparam int ACC_W  = W + 1;
  localparam int PERIOD = 2 * HALF_DIV;
  localparam int PH_W   = $clog2(PERIOD);
  localparam int DEC_W  = $clog2(DECIM);
  localparam int WRM_W  = $clog2(WARMUP + 2);

  localparam logic signed [ACC_W-1:0] PLUS_ONE  = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MINUS_ONE = '1;
  localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'((1 << (W - 1)) - 1);
  // Top BIT_WIDTH bits of the saturated positive maximum.
  localparam logic [BIT_WIDTH-1:0]    SAT_TOP   = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic [BIT_WIDTH-1:0]    LANE_RST  = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic                 emit;
  logic [PH_W-1:0]      ph_reg, ph_inc;
  logic                 pdm_clk_reg;
  logic [DEC_W-1:0]     dec_reg;
  logic                 frame_done_reg;
  logic [WRM_W-1:0]     warm_reg;
  logic [NUM_MICS-1:0]  sync1_reg, sync2_reg;
  logic                 pcm_valid_reg;
  logic                 strobe, going_idle, comb_en;
  logic [BIT_WIDTH-1:0] lane_reg [NUM_MICS];
  logic [BIT_WIDTH*NUM_MICS-1:0] pcm_flat;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // emit: this cycle's completed frame goes to the output (registered next edge).
  always_comb begin
    state_next = state_reg;
    emit       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.enable) state_next = S_WARMUP;
      end
      S_WARMUP: begin
        if (!bus.enable) begin
          state_next = S_IDLE;
        end else if (frame_done_reg && (warm_reg == WRM_W'(WARMUP))) begin
          state_next = S_RUN;
          emit       = 1'b1;
        end
      end
      S_RUN: begin
        if (!bus.enable)         state_next = S_IDLE;
        else if (frame_done_reg) emit       = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- shared timing
  assign going_idle = (state_next == S_IDLE);
  assign ph_inc     = (ph_reg == PH_W'(PERIOD - 1)) ? '0 : ph_reg + PH_W'(1);
  // Sample at the last cycle of the low phase, just before the rising edge.
  assign strobe     = (state_reg != S_IDLE) && (ph_reg == PH_W'(PERIOD - 1));
  // A frame finishing on the cycle enable drops is discarded with the rest.
  assign comb_en    = frame_done_reg && !going_idle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= bus.pdm_data_in;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || going_idle) begin
      ph_reg         <= '0;
      pdm_clk_reg    <= 1'b0;
      dec_reg        <= '0;
      frame_done_reg <= 1'b0;
      warm_reg       <= '0;
      pcm_valid_reg  <= 1'b0;
    end else begin
      pcm_valid_reg  <= emit;
      frame_done_reg <= strobe && (dec_reg == DEC_W'(DECIM - 1));
      if (state_reg == S_IDLE) begin
        // Start: first PDM clock high phase begins immediately at ph = 0.
        ph_reg      <= '0;
        pdm_clk_reg <= 1'b1;
      end else begin
        ph_reg      <= ph_inc;
        pdm_clk_reg <= (ph_inc < PH_W'(HALF_DIV));
      end
      if (strobe) begin
        dec_reg <= (dec_reg == DEC_W'(DECIM - 1)) ? '0 : dec_reg + DEC_W'(1);
      end
      if (frame_done_reg && (state_reg == S_WARMUP) && (warm_reg != WRM_W'(WARMUP))) begin
        warm_reg <= warm_reg + WRM_W'(1);
      end
    end
  end

  // ------------------------------------------------------- per-mic CIC
  generate
    for (genvar gi = 0; gi < NUM_MICS; gi++) begin : g_mic
      logic signed [ACC_W-1:0] i1_reg, i2_reg, i3_reg;
      logic signed [ACC_W-1:0] d1_reg, d2_reg, d3_reg;
      logic signed [ACC_W-1:0] x, i1_next, i2_next, i3_next, c1, c2, c3;
      logic [BIT_WIDTH-1:0]    sat_top, lane_next;

      assign x       = sync2_reg[gi] ? PLUS_ONE : MINUS_ONE;
      // Non-pipelined cascade so the frame's last bit is in i3 one cycle later.
      assign i1_next = i1_reg + x;
      assign i2_next = i2_reg + i1_next;
      assign i3_next = i3_reg + i2_next;
      assign c1      = i3_reg - d1_reg;
      assign c2      = c1 - d2_reg;
      assign c3      = c2 - d3_reg;
      assign sat_top = (c3 > SAT_MAX) ? SAT_TOP : c3[W-1 -: BIT_WIDTH];
      // Offset binary: flip the sign bit so silence reads as mid-scale.
      assign lane_next = {~sat_top[BIT_WIDTH-1], sat_top[BIT_WIDTH-2:0]};

      always_ff @(posedge clk) begin
        if (!rst_n || going_idle) begin
          i1_reg <= '0;
          i2_reg <= '0;
          i3_reg <= '0;
          d1_reg <= '0;
          d2_reg <= '0;
          d3_reg <= '0;
        end else begin
          if (strobe) begin
            i1_reg <= i1_next;
            i2_reg <= i2_next;
            i3_reg <= i3_next;
          end
          if (comb_en) begin
            d1_reg <= i3_reg;
            d2_reg <= c1;
            d3_reg <= c2;
          end
        end
      end

      // Output lanes survive enable drops; only reset returns them to mid-scale.
      always_ff @(posedge clk) begin
        if (!rst_n)    lane_reg[gi] <= LANE_RST;
        else if (emit) lane_reg[gi] <= lane_next;
      end

      assign pcm_flat[BIT_WIDTH*gi +: BIT_WIDTH] = lane_reg[gi];
    end
  endgenerate

  assign bus.pdm_clk_out  = pdm_clk_reg;
  assign bus.pcm_data_out = pcm_flat;
  assign bus.pcm_valid    = pcm_valid_reg;
  assign bus.active       = (state_reg == S_RUN);
endmodule

// File: tb/tb_pdm_capture.sv
// tb_pdm_capture -- self-checking bench for pdm_capture.
// Drives periodic PDM patterns whose decimated output is known in closed form
// (DC level times DECIM^3), checks reset values, PDM clock waveform, warmup
// and frame cadence, enable drop/re-enable and mid-run reset.
module tb_pdm_capture;
  localparam int BW          = 8;
  localparam int NM          = 25;
  localparam int HD          = 12;
  localparam int DC          = 64;
  localparam int WU          = 4;
  localparam int FRAME       = 2 * HD * DC;          // 1536 cycles
  localparam int FIRST_VALID = FRAME * (WU + 1) + 1; // negedges after start edge

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pdm_capture_if #(.BIT_WIDTH(BW), .NUM_MICS(NM)) bus ();

  pdm_capture #(
    .BIT_WIDTH(BW), .NUM_MICS(NM), .HALF_DIV(HD), .DECIM(DC), .WARMUP(WU)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pattern codes: 0 zeros, 1 ones, 2 1010.., 3 1110.., 4 1000.., 5 11111110.., 6 1100..
  typedef struct {
    logic [2:0] p0, p1, p2;
    logic [7:0] e0, e1, e2;
  } vec_t;

  vec_t        vecs [4];
  logic [2:0]  cur_pat [3];
  int unsigned bit_n = 0;

  function automatic logic pat_bit(input logic [2:0] pat, input int unsigned n);
    case (pat)
      3'd0:    return 1'b0;
      3'd1:    return 1'b1;
      3'd2:    return (n % 2) == 0;
      3'd3:    return (n % 4) != 3;
      3'd4:    return (n % 4) == 0;
      3'd5:    return (n % 8) != 7;
      3'd6:    return (n % 4) < 2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] exp_lane(input vec_t v, input int k);
    case (k % 3)
      0:       return v.e0;
      1:       return v.e1;
      default: return v.e2;
    endcase
  endfunction

  // Mic model: new bit shortly after each falling edge of the PDM clock.
  initial begin
    bus.pdm_data_in = '0;
    forever begin
      @(negedge bus.pdm_clk_out);
      bit_n++;
      for (int k = 0; k < NM; k++) bus.pdm_data_in[k] = pat_bit(cur_pat[k % 3], bit_n);
    end
  end

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic check_lanes(input string name, input vec_t v);
    for (int k = 0; k < NM; k++)
      check_eq($sformatf("%s lane%0d", name, k), 64'(bus.pcm_data_out[BW*k +: BW]), 64'(exp_lane(v, k)));
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.pcm_valid !== 1'b1 && n < 2 * FRAME);
    checks++;
    if (bus.pcm_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: no pcm_valid within %0d cycles, expected one", name, n);
    end
  endtask

  task automatic set_pat(input vec_t v);
    cur_pat[0] = v.p0;
    cur_pat[1] = v.p1;
    cur_pat[2] = v.p2;
  endtask

  // Call right after the start condition was applied at a negedge; index 0 is
  // the negedge after the starting clock edge. Ends on the second pcm_valid.
  task automatic run_start(input string name);
    int clk_bad, valid_bad, act_bad, first, second;
    logic exp_valid;
    clk_bad = 0; valid_bad = 0; act_bad = 0; first = -1; second = -1;
    for (int i = 0; i <= FIRST_VALID + FRAME; i++) begin
      @(negedge clk);
      exp_valid = (i >= FIRST_VALID) && (((i - FIRST_VALID) % FRAME) == 0);
      if (bus.pdm_clk_out !== ((i % (2 * HD)) < HD)) clk_bad++;
      if (bus.pcm_valid !== exp_valid) valid_bad++;
      if (bus.active !== (i >= FIRST_VALID)) act_bad++;
      if (bus.pcm_valid === 1'b1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    check_eq({name, " pdm_clk wave errors"}, 64'(clk_bad), 64'd0);
    check_eq({name, " pcm_valid wave errors"}, 64'(valid_bad), 64'd0);
    check_eq({name, " active wave errors"}, 64'(act_bad), 64'd0);
    check_eq({name, " first valid index"}, 64'(first), 64'(FIRST_VALID));
    check_eq({name, " valid interval"}, 64'(second - first), 64'(FRAME));
  endtask

  initial begin
    int bad;
    vecs[0] = '{3'd1, 3'd0, 3'd2, 8'hFF, 8'h00, 8'h80};
    vecs[1] = '{3'd3, 3'd4, 3'd6, 8'hC0, 8'h40, 8'h80};
    vecs[2] = '{3'd5, 3'd2, 3'd1, 8'hE0, 8'h80, 8'hFF};
    vecs[3] = '{3'd0, 3'd1, 3'd3, 8'h00, 8'hFF, 8'hC0};
    set_pat(vecs[0]);

    // Reset with enable high.
    rst_n      = 1'b0;
    bus.enable = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("reset pdm_clk_out", 64'(bus.pdm_clk_out), 64'd0);
    check_eq("reset pcm_valid", 64'(bus.pcm_valid), 64'd0);
    check_eq("reset active", 64'(bus.active), 64'd0);
    check_lanes("reset", '{3'd0, 3'd0, 3'd0, 8'h80, 8'h80, 8'h80});

    rst_n      = 1'b1;
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle pdm_clk_out", 64'(bus.pdm_clk_out), 64'd0);
    check_eq("idle active", 64'(bus.active), 64'd0);

    // First start: clock waveform, warmup suppression, cadence.
    bus.enable = 1'b1;
    run_start("start");
    check_lanes("start", vecs[0]);

    // Table: apply pattern, let three frames settle, check the fourth.
    for (int r = 0; r < 4; r++) begin
      set_pat(vecs[r]);
      for (int f = 0; f < 3; f++) wait_valid($sformatf("row%0d settle", r));
      wait_valid($sformatf("row%0d", r));
      check_lanes($sformatf("row%0d", r), vecs[r]);
    end

    // Enable drop on the cycle before the frame would be output.
    repeat (FRAME - 1) @(negedge clk);
    check_eq("pre-drop pdm_clk_out", 64'(bus.pdm_clk_out), 64'd1);
    bus.enable = 1'b0;
    @(negedge clk);
    check_eq("drop pcm_valid", 64'(bus.pcm_valid), 64'd0);
    check_eq("drop pdm_clk_out", 64'(bus.pdm_clk_out), 64'd0);
    check_eq("drop active", 64'(bus.active), 64'd0);
    check_lanes("drop hold", vecs[3]);
    bad = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (bus.pcm_valid !== 1'b0 || bus.pdm_clk_out !== 1'b0 || bus.active !== 1'b0) bad++;
    end
    check_eq("disabled quiet errors", 64'(bad), 64'd0);

    // Re-enable restarts warmup from cleared filters.
    bus.enable = 1'b1;
    run_start("reenable");
    check_lanes("reenable", vecs[3]);

    // Mid-run reset with enable held high.
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midreset pdm_clk_out", 64'(bus.pdm_clk_out), 64'd0);
    check_eq("midreset pcm_valid", 64'(bus.pcm_valid), 64'd0);
    check_eq("midreset active", 64'(bus.active), 64'd0);
    check_lanes("midreset", '{3'd0, 3'd0, 3'd0, 8'h80, 8'h80, 8'h80});
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    run_start("after_reset");
    check_lanes("after_reset", vecs[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
